count_display: RTL and testbench
================================

# count_display

Display and monitor stage that sits directly downstream of the 4-bit up/down counter. It samples the counter value `Q` and direction `S`, drives a two-digit multiplexed common-anode seven-segment display showing the value in decimal (00–15), and flags counter wrap-around events. All outputs are registered, and the block runs on the same clock as the counter.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit stays lit; legal range ≥ 2.
- `clk` input 1: single system clock; all logic on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `S` input 1: counter direction; 1 = up, 0 = down.
- `Q` input 4: counter value, 0–15.
- `seg` output 7: segments {g,f,e,d,c,b,a}, active-low.
- `an` output 2: digit anodes, active-low; bit0 = ones digit, bit1 = tens digit.
- `dp` output 1: decimal point, active-low.
- `wrap_up` output 1: one-cycle pulse on a 15→0 transition.
- `wrap_down` output 1: one-cycle pulse on a 0→15 transition.

## Operation
- Input stage: `Q` and `S` are registered every cycle into `q_r` and `s_r`. `q_r` is copied into `q_prev` every cycle.
- `prev_vld` clears on reset and sets after the first post-reset sample. Wrap detection is suppressed while `prev_vld` = 0.
- Wrap detect:
  - `wrap_up` asserts when `q_prev` = 15 and `q_r` = 0.
  - `wrap_down` asserts when `q_prev` = 0 and `q_r` = 15.
  - Detection is based on value only. `S` is not consulted, so a direction change at a boundary is still classified by the value pair.
  - The two pulses are mutually exclusive. A held value produces no pulse.
- BCD split (5-bit compare, no divider):
  - tens = 1 if `q_r` ≥ 10, else 0.
  - ones = `q_r` − 10 if `q_r` ≥ 10, else `q_r`.
- Leading-zero blanking: when tens = 0, the tens digit drives `seg` = 7'h7F (all segments off) during its scan slot.
- Scan FSM, 2 states:
  - ONES: `an` = 2'b10, shows the ones digit.
  - TENS: `an` = 2'b01, shows the tens digit or blank.
  - A timer counts 0..`SCAN_DIV`−1. At terminal count the timer returns to 0 and the state toggles ONES↔TENS.
- Segment encoding is the standard hex 0–9 pattern, e.g. 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000.
- Both digits are never lit at the same time. `an` = 2'b11 only during reset.

## Timing
- Reset values, applied at the first clock edge with `rst_n` = 0:
  - `seg` = 7'h7F, `an` = 2'b11, `dp` = 1, `wrap_up` = 0, `wrap_down` = 0.
  - timer = 0, FSM = ONES, `q_r` = 0, `q_prev` = 0, `prev_vld` = 0.
- First edge with `rst_n` = 1: `q_r` is loaded. The display outputs become valid at the following edge, in the ONES state.
- Display latency: a `Q` change sampled at edge n appears on `seg` after edge n+1, provided the current digit is the one affected.
- Wrap latency: if `Q` takes the new value at edge n, the pulse is high for exactly the cycle after edge n+1.
- Reset asserted mid-scan or mid-pulse takes effect at the next edge, overriding everything. No wrap is reported across a reset.
- The timer terminal count and a `Q` change in the same cycle are independent. The new digit state uses the freshly sampled value.

## Configuration
- `COUNT_DISPLAY_DIR_DP_EN` defined: `dp` = 0 (lit) during the ONES slot when `s_r` = 1 (up); otherwise `dp` = 1.
- Not defined: `dp` is held at 1 permanently and `s_r` is unused (may be optimised away).

## Structure
- Package `count_display_pkg`:
  - seven-segment pattern constants for 0–9 and blank;
  - anode constants `AN_ONES`, `AN_TENS`, `AN_OFF`;
  - scan-state typedef {ONES, TENS}.
- Sub-module `seg7_decode`: purely combinational 4-bit digit plus blank flag → 7-bit active-low pattern. Instantiated once on the selected digit.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles with `Q` = 9 → `seg` = 7'h7F, `an` = 2'b11, `wrap_*` = 0. Release → within 2 cycles `an` = 2'b10, `seg` = 7'b0010000 (digit 9).
- Decimal split, `SCAN_DIV` = 4, `Q` = 13 held → ONES slot shows 3 (7'b0110000) for 4 cycles, then TENS slot shows 1 (7'b1111001) for 4 cycles, alternating.
- Blanking: `Q` = 7 → tens slot `seg` = 7'h7F with `an` = 2'b01; ones slot shows 7 (7'b1111000).
- Wrap: `Q` sequence 14, 15, 0 with `S` = 1 → single-cycle `wrap_up` 2 edges after `Q` = 0. Sequence 1, 0, 15 with `S` = 0 → single `wrap_down`. Hold at 0 → no pulse.
- Reset mid-sequence: `Q` = 15, assert reset for 1 cycle, release with `Q` = 0 → no `wrap_up`.
- Macro: with `COUNT_DISPLAY_DIR_DP_EN` defined and `S` = 1 → `dp` = 0 in the ONES slot, 1 in the TENS slot; with `S` = 0 → `dp` = 1 always. Without the macro → `dp` = 1 always.

Source files
------------

// File: rtl/count_display_pkg.sv
// Shared constants and types for the count_display block.
// Seven-segment patterns are {g,f,e,d,c,b,a}, active-low.
package count_display_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;
  localparam logic [1:0] AN_OFF  = 2'b11;

  localparam logic [4:0] BCD_TEN = 5'd10;

  typedef enum logic {
    ONES,
    TENS
  } scan_e;

endpackage

// File: rtl/count_display_if.sv
// Counter-to-display bundle: counter value/direction in,
// segment, anode, decimal point and wrap pulses out.
interface count_display_if;

  logic       S;
  logic [3:0] Q;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp;
  logic       wrap_up;
  logic       wrap_down;

  modport master (
    output S,
    output Q,
    input  seg,
    input  an,
    input  dp,
    input  wrap_up,
    input  wrap_down
  );

  modport slave (
    input  S,
    input  Q,
    output seg,
    output an,
    output dp,
    output wrap_up,
    output wrap_down
  );

endinterface

// File: rtl/count_display_seg7.sv
// Combinational BCD digit to active-low seven-segment pattern.
// blank_i forces all segments off.
module seg7_decode
  import count_display_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      unique case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/count_display.sv
// Two-digit multiplexed display and wrap monitor for a 4-bit counter.
// Define COUNT_DISPLAY_DIR_DP_EN to light dp in the ones slot when counting up.
module count_display
  import count_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input logic            clk,
  input logic            rst_n,
  count_display_if.slave dsp
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] TC = TW'(SCAN_DIV - 1);

  logic [3:0]    qr_q, qprev_q;
  logic          sr_q;
  logic          samp_vld_q, prev_vld_q;
  logic [TW-1:0] timer_q, timer_d;
  scan_e         state_q, state_d;
  logic [6:0]    seg_q;
  logic [6:0]    seg_d;
  logic [1:0]    an_q, an_d;
  logic          dp_q, dp_d;
  logic          wup_q, wup_d;
  logic          wdn_q, wdn_d;

  logic          tc;
  logic          ge10;
  logic [3:0]    ones;
  logic [3:0]    digit;
  logic          blank;

  always_comb begin
    tc      = (timer_q == TC);
    timer_d = tc ? '0 : timer_q + 1'b1;
    state_d = state_q;
    if (tc) state_d = (state_q == ONES) ? TENS : ONES;

    ge10  = ({1'b0, qr_q} >= BCD_TEN);
    ones  = ge10 ? (qr_q - 4'd10) : qr_q;
    digit = (state_q == ONES) ? ones : {3'b000, ge10};
    blank = (state_q == TENS) && !ge10;
    an_d  = (state_q == ONES) ? AN_ONES : AN_TENS;

    // Classified purely by value pair; direction is ignored.
    wup_d = prev_vld_q && (qprev_q == 4'd15) && (qr_q == 4'd0);
    wdn_d = prev_vld_q && (qprev_q == 4'd0) && (qr_q == 4'd15);
  end

`ifdef COUNT_DISPLAY_DIR_DP_EN
  assign dp_d = !((state_q == ONES) && sr_q);
`else
  logic unused_sr;
  assign unused_sr = sr_q;
  assign dp_d      = 1'b1;
`endif

  seg7_decode u_dec (
    .digit_i (digit),
    .blank_i (blank),
    .seg_o   (seg_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qr_q       <= 4'd0;
      qprev_q    <= 4'd0;
      sr_q       <= 1'b0;
      samp_vld_q <= 1'b0;
      prev_vld_q <= 1'b0;
      timer_q    <= '0;
      state_q    <= ONES;
      seg_q      <= SEG_BLANK;
      an_q       <= AN_OFF;
      dp_q       <= 1'b1;
      wup_q      <= 1'b0;
      wdn_q      <= 1'b0;
    end else begin
      qr_q       <= dsp.Q;
      sr_q       <= dsp.S;
      qprev_q    <= qr_q;
      // q_prev only holds a real sample one edge after q_r does.
      samp_vld_q <= 1'b1;
      prev_vld_q <= samp_vld_q;
      timer_q    <= timer_d;
      state_q    <= state_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
      wup_q      <= wup_d;
      wdn_q      <= wdn_d;
    end
  end

  assign dsp.seg       = seg_q;
  assign dsp.an        = an_q;
  assign dsp.dp        = dp_q;
  assign dsp.wrap_up   = wup_q;
  assign dsp.wrap_down = wdn_q;

endmodule

// File: tb/tb_count_display.sv
// Directed bench for count_display with SCAN_DIV = 4.
// Works with or without COUNT_DISPLAY_DIR_DP_EN.
module tb_count_display;

`ifdef COUNT_DISPLAY_DIR_DP_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  count_display_if bus ();

  count_display #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dsp   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [3:0] q, input logic s);
    rst_n = 1'b0;
    bus.Q = q;
    bus.S = s;
    tick(1);
    rst_n = 1'b1;
  endtask

  task automatic run_split(input logic [3:0] q, input logic s,
                           input logic [6:0] e_ones,
                           input logic [6:0] e_tens);
    bit is_ones;
    apply_reset(q, s);
    tick(1);
    for (int k = 2; k <= 12; k++) begin
      tick(1);
      is_ones = (((k - 1) / 4) % 2) == 0;
      check("an", bus.an, is_ones ? 2'b10 : 2'b01);
      check("seg", bus.seg, is_ones ? e_ones : e_tens);
      check("dp", bus.dp, (DP_EN && is_ones && s) ? 1'b0 : 1'b1);
      check("wrap", {bus.wrap_up, bus.wrap_down}, 2'b00);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.Q = 4'd9;
    bus.S = 1'b1;
    tick(3);
    check("rst_seg", bus.seg, 7'h7F);
    check("rst_an", bus.an, 2'b11);
    check("rst_dp", bus.dp, 1'b1);
    check("rst_wup", bus.wrap_up, 1'b0);
    check("rst_wdn", bus.wrap_down, 1'b0);
    rst_n = 1'b1;
    tick(2);
    check("rel_an", bus.an, 2'b10);
    check("rel_seg", bus.seg, 7'b0010000);

    run_split(4'd13, 1'b1, 7'b0110000, 7'b1111001);
    run_split(4'd7, 1'b0, 7'b1111000, 7'h7F);
    run_split(4'd10, 1'b1, 7'b1000000, 7'b1111001);
    run_split(4'd0, 1'b0, 7'b1000000, 7'h7F);
    run_split(4'd15, 1'b1, 7'b0010010, 7'b1111001);

    // 14 -> 15 -> 0 counting up
    apply_reset(4'd14, 1'b1);
    tick(2);
    bus.Q = 4'd15;
    tick(1);
    bus.Q = 4'd0;
    tick(1);
    check("wup_early", bus.wrap_up, 1'b0);
    tick(1);
    check("wup_pulse", bus.wrap_up, 1'b1);
    check("wup_wdn", bus.wrap_down, 1'b0);
    tick(1);
    check("wup_end", bus.wrap_up, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("hold0", {bus.wrap_up, bus.wrap_down}, 2'b00);
    end

    // 1 -> 0 -> 15 counting down
    apply_reset(4'd1, 1'b0);
    tick(2);
    bus.Q = 4'd0;
    tick(1);
    bus.Q = 4'd15;
    tick(1);
    check("wdn_early", bus.wrap_down, 1'b0);
    tick(1);
    check("wdn_pulse", bus.wrap_down, 1'b1);
    check("wdn_wup", bus.wrap_up, 1'b0);
    tick(1);
    check("wdn_end", bus.wrap_down, 1'b0);

    // Direction flag does not affect classification
    apply_reset(4'd15, 1'b0);
    tick(2);
    bus.Q = 4'd0;
    tick(2);
    check("wup_dirS0", bus.wrap_up, 1'b1);

    // Reset across a 15 -> 0 step hides the wrap
    apply_reset(4'd15, 1'b1);
    tick(4);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    bus.Q = 4'd0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("rst_nowrap", {bus.wrap_up, bus.wrap_down}, 2'b00);
    end

    // Reset arriving on the pulse edge wins
    apply_reset(4'd15, 1'b1);
    tick(2);
    bus.Q = 4'd0;
    tick(1);
    rst_n = 1'b0;
    tick(1);
    check("rst_pulse", bus.wrap_up, 1'b0);
    check("rst_pulse_an", bus.an, 2'b11);
    rst_n = 1'b1;
    tick(3);
    check("post_rst", bus.wrap_up, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
